// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - FoosballStars match sequencer: start debounce, kickoff/serve countdown, scoring, winner
// Optional pause/freeze support is built when MATCH_CTRL_PAUSE_EN is defined.

module match_ctrl_debounce #(
  parameter int TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic evt
);

  logic       sync_1;
  logic       sync_2;
  logic [3:0] cnt;
  logic       full;
  logic       full_q;

  assign full = (cnt == 4'(TICKS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= 4'd0;
      full_q <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      if (!sync_2) begin
        cnt <= 4'd0;
      end else if (tick && !full) begin
        cnt <= cnt + 4'd1;
      end
      full_q <= full;
    end
  end

  // One clk pulse when the button has been seen high for TICKS frame ticks.
  assign evt = full & ~full_q;

endmodule

module match_ctrl #(
  parameter int TICK_DIV       = 830000,
  parameter int SERVE_DELAY    = 60,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int WIN_SCORE      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic       anim_reset,
  output logic       stop_ball,
  output logic       freeze,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_KICKOFF    = 3'd1,
    S_PLAY       = 3'd2,
    S_GOAL_PAUSE = 3'd3,
    S_OVER       = 3'd4
  } state_t;

  localparam int TW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          start_evt;
  logic          frozen;

  state_t        state;
  state_t        state_d;
  logic [7:0]    cd;
  logic [7:0]    cd_d;
  logic [3:0]    p1_d;
  logic [3:0]    p2_d;
  logic [1:0]    winner_d;
  logic          stop_d;

  logic          g1;
  logic          g2;
  logic [3:0]    n1;
  logic [3:0]    n2;
  logic          hit1;
  logic          hit2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TW'(TICK_DIV)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == '0);

  match_ctrl_debounce #(.TICKS(DEBOUNCE_TICKS)) u_start_db (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .btn   (start_btn),
    .evt   (start_evt)
  );

`ifdef MATCH_CTRL_PAUSE_EN
  logic pause_evt;

  match_ctrl_debounce #(.TICKS(DEBOUNCE_TICKS)) u_pause_db (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .btn   (pause_btn),
    .evt   (pause_evt)
  );

  // Freeze only lives inside PLAY; any exit from PLAY drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freeze <= 1'b0;
    end else if (state_d != S_PLAY) begin
      freeze <= 1'b0;
    end else if (state == S_PLAY && pause_evt) begin
      freeze <= ~freeze;
    end
  end

  assign frozen = freeze;
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
  assign freeze       = 1'b0;
  assign frozen       = 1'b0;
`endif

  assign g1   = goal_p1 & ~frozen;
  assign g2   = goal_p2 & ~frozen;
  assign n1   = (g1 && p1_score != 4'hF) ? p1_score + 4'd1 : p1_score;
  assign n2   = (g2 && p2_score != 4'hF) ? p2_score + 4'd1 : p2_score;
  assign hit1 = (n1 >= 4'(WIN_SCORE));
  assign hit2 = (n2 >= 4'(WIN_SCORE));

  always_comb begin
    state_d  = state;
    cd_d     = cd;
    p1_d     = p1_score;
    p2_d     = p2_score;
    winner_d = winner;
    stop_d   = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (start_evt) begin
          state_d  = S_KICKOFF;
          cd_d     = 8'(SERVE_DELAY);
          p1_d     = 4'd0;
          p2_d     = 4'd0;
          winner_d = 2'b00;
        end
      end
      S_KICKOFF, S_GOAL_PAUSE: begin
        if (tick && cd != 8'd0) begin
          if (cd == 8'd1) begin
            state_d = S_PLAY;
            stop_d  = 1'b1;
          end
          cd_d = cd - 8'd1;
        end
      end
      S_PLAY: begin
        if (g1 || g2) begin
          p1_d = n1;
          p2_d = n2;
          if (hit1 || hit2) begin
            state_d  = S_OVER;
            winner_d = {hit2, hit1};
          end else begin
            state_d = S_GOAL_PAUSE;
            cd_d    = 8'(SERVE_DELAY);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cd         <= 8'd0;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      winner     <= 2'b00;
      stop_ball  <= 1'b0;
      anim_reset <= 1'b1;
    end else begin
      state      <= state_d;
      cd         <= cd_d;
      p1_score   <= p1_d;
      p2_score   <= p2_d;
      winner     <= winner_d;
      stop_ball  <= stop_d;
      anim_reset <= (state_d == S_IDLE) || (state_d == S_OVER);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_match_ctrl.sv
// tb/tb_match_ctrl.sv - directed self-checking bench for match_ctrl
// Exercises the pause feature when MATCH_CTRL_PAUSE_EN is defined.

module tb_match_ctrl;

  localparam int TICK_DIV       = 3;
  localparam int SERVE_DELAY    = 2;
  localparam int DEBOUNCE_TICKS = 2;
  localparam int WIN_SCORE      = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       goal_p1 = 1'b0;
  logic       goal_p2 = 1'b0;
  logic       anim_reset;
  logic       stop_ball;
  logic       freeze;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  int phase;

  match_ctrl #(
    .TICK_DIV       (TICK_DIV),
    .SERVE_DELAY    (SERVE_DELAY),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .WIN_SCORE      (WIN_SCORE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .goal_p1    (goal_p1),
    .goal_p2    (goal_p2),
    .anim_reset (anim_reset),
    .stop_ball  (stop_ball),
    .freeze     (freeze),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .winner     (winner),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // Frame-tick phase: a tick is present in any cycle where phase is 0.
  always @(posedge clk or posedge reset) begin
    if (reset) phase <= 0;
    else       phase <= (phase == TICK_DIV) ? 0 : phase + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Press start at a negedge; state 1 must appear 8..11 clks later.
  task automatic press_start(input string tag);
    int lat = 0;
    start_btn = 1'b1;
    while (state_o != 3'd1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, int'(lat >= 8 && lat <= 11), 1);
    start_btn = 1'b0;
  endtask

  // Called on the first cycle of KICKOFF/GOAL_PAUSE; serve follows the SERVE_DELAY-th tick.
  task automatic serve(input string tag, input logic inj_p2);
    int   ticks = 0;
    int   n = 0;
    logic early = 1'b0;
    while (ticks < SERVE_DELAY && n < 60) begin
      if (n == 0) goal_p2 = inj_p2;
      if (phase == 0) ticks++;
      if (stop_ball) early = 1'b1;
      @(negedge clk);
      n++;
      goal_p2 = 1'b0;
    end
    check({tag, "_early"}, int'(early), 0);
    check({tag, "_stop"}, int'(stop_ball), 1);
    check({tag, "_state"}, int'(state_o), 2);
    check({tag, "_anim"}, int'(anim_reset), 0);
    @(negedge clk);
    check({tag, "_stop_end"}, int'(stop_ball), 0);
  endtask

  task automatic goal(input logic a, input logic b);
    goal_p1 = a;
    goal_p2 = b;
    @(negedge clk);
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
  endtask

  initial begin
    logic flag;
    int   n;

    repeat (2) @(negedge clk);
    check("rst_state", int'(state_o), 0);
    check("rst_anim", int'(anim_reset), 1);
    check("rst_stop", int'(stop_ball), 0);
    check("rst_freeze", int'(freeze), 0);
    check("rst_p1", int'(p1_score), 0);
    check("rst_p2", int'(p2_score), 0);
    check("rst_win", int'(winner), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_hold", int'(state_o), 0);

    press_start("start");
    serve("kick", 1'b0);

    goal(1'b1, 1'b0);
    check("g1_p1", int'(p1_score), 1);
    check("g1_state", int'(state_o), 3);
    serve("gp1", 1'b1);
    check("gp_p2_drop", int'(p2_score), 0);

    goal(1'b1, 1'b0);
    check("g2_p1", int'(p1_score), 2);
    serve("gp2", 1'b0);
    goal(1'b1, 1'b0);
    check("win_p1", int'(p1_score), 3);
    check("win_state", int'(state_o), 4);
    check("win_winner", int'(winner), 1);
    check("win_anim", int'(anim_reset), 1);
    goal(1'b0, 1'b1);
    check("over_p2_drop", int'(p2_score), 0);
    check("over_hold", int'(state_o), 4);

    repeat (4) @(negedge clk);
    press_start("restart");
    check("restart_p1", int'(p1_score), 0);
    check("restart_win", int'(winner), 0);
    check("restart_anim", int'(anim_reset), 0);
    serve("kick2", 1'b0);

    goal(1'b1, 1'b0); serve("d1", 1'b0);
    goal(1'b0, 1'b1); serve("d2", 1'b0);
    goal(1'b1, 1'b0); serve("d3", 1'b0);
    goal(1'b0, 1'b1);
    check("two_all_p1", int'(p1_score), 2);
    check("two_all_p2", int'(p2_score), 2);
    serve("d4", 1'b0);
    goal(1'b1, 1'b1);
    check("draw_p1", int'(p1_score), 3);
    check("draw_p2", int'(p2_score), 3);
    check("draw_winner", int'(winner), 3);
    check("draw_state", int'(state_o), 4);

    repeat (4) @(negedge clk);
    press_start("restart2");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_state", int'(state_o), 0);
    check("mid_rst_anim", int'(anim_reset), 1);
    check("mid_rst_stop", int'(stop_ball), 0);
    check("mid_rst_win", int'(winner), 0);
    @(negedge clk);
    reset = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stop_ball || state_o != 3'd0) flag = 1'b1;
    end
    check("post_rst_quiet", int'(flag), 0);

    press_start("start3");
    serve("kick3", 1'b0);
`ifdef MATCH_CTRL_PAUSE_EN
    pause_btn = 1'b1;
    n = 0;
    while (freeze !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("pause_on", int'(freeze), 1);
    pause_btn = 1'b0;
    goal(1'b1, 1'b0);
    check("frozen_p1", int'(p1_score), 0);
    check("frozen_state", int'(state_o), 2);
    repeat (6) @(negedge clk);
    pause_btn = 1'b1;
    n = 0;
    while (freeze !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("pause_off", int'(freeze), 0);
    pause_btn = 1'b0;
`else
    pause_btn = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (freeze) flag = 1'b1;
    end
    pause_btn = 1'b0;
    check("no_freeze", int'(flag), 0);
`endif
    goal(1'b1, 1'b0);
    check("live_p1", int'(p1_score), 1);
    check("live_state", int'(state_o), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
